// File: rtl/store_size_pkg.sv
// Shared definitions for the store formatting path.
//   - Store size encodings, common with the load formatter's control field.
//   - FSM state type for store_size_rmw.
//   - Request legality helper used at capture time.
package store_size_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WAIT   = 3'd2,
        WRITE  = 3'd3,
        FINISH = 3'd4
    } state_t;

    // A request is rejected when the size code is reserved or the address
    // is not naturally aligned for the access size.
    function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_WORD: bad = (off != 2'b00);
            SZ_HALF: bad = off[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge for sub-word stores (little-endian).
// Ports:
//   old_word_i   : word read back from memory
//   store_data_i : source register value (low 8/16 bits used for SB/SH)
//   size_i       : store size encoding
//   offset_i     : byte offset within the word (store_addr[1:0])
//   merged_o     : word to write back
module store_lane_merge
    import store_size_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] store_data_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] merged_o
);

    always_comb begin
        merged_o = old_word_i;
        case (size_i)
            SZ_WORD: merged_o = store_data_i;
            SZ_HALF: begin
                if (offset_i[1]) merged_o[31:16] = store_data_i[15:0];
                else             merged_o[15:0]  = store_data_i[15:0];
            end
            SZ_BYTE: merged_o[{offset_i, 3'b000} +: 8] = store_data_i[7:0];
            default: merged_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/store_size_rmw.sv
// Store path between the multicycle controller and the data memory port.
// SW writes directly; SH/SB read the containing word, merge the new lane and
// write the word back. Misaligned or reserved-size requests finish with err.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : one-cycle request, only accepted in IDLE
//   size_sel              : 00 word, 01 half, 10 byte, 11 illegal
//   store_addr/store_data : byte address and source value
//   mem_addr              : word-aligned address, held for the operation
//   mem_rd/mem_rdata      : read strobe and returned data
//   mem_wr/mem_wdata      : write strobe and merged word
//   busy, done, err       : status; err is valid with the done pulse
module store_size_rmw
    import store_size_pkg::*;
#(
    parameter int MEM_READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  size_sel,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_data,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CNT_W = 2;

    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] data_q, data_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] merged;

    store_lane_merge u_merge (
        .old_word_i   (mem_rdata),
        .store_data_i (data_q),
        .size_i       (size_q),
        .offset_i     (off_q),
        .merged_o     (merged)
    );

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        off_d   = off_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    size_d = size_sel;
                    off_d  = store_addr[1:0];
                    data_d = store_data;
                    addr_d = {store_addr[31:2], 2'b00};
                    err_d  = req_illegal(size_sel, store_addr[1:0]);
                    if (req_illegal(size_sel, store_addr[1:0])) begin
                        state_d = FINISH;
                    end else if (size_sel == SZ_WORD) begin
                        wdata_d = store_data;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                cnt_d   = CNT_W'(MEM_READ_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                // Read data is valid exactly when the countdown reaches zero.
                if (cnt_q == '0) begin
                    wdata_d = merged;
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WRITE:  state_d = FINISH;
            FINISH: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            size_q  <= '0;
            off_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            off_q   <= off_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode from the state register only, so an asynchronous reset
    // drops mem_wr immediately and no partial write can complete.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rd    = (state_q == READ);
    assign mem_wr    = (state_q == WRITE);
    assign busy      = (state_q != IDLE) && (state_q != FINISH);
    assign done      = (state_q == FINISH);
    assign err       = err_q;

endmodule

// File: tb/tb_store_size_rmw.sv
module tb_store_size_rmw;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start1, start3;
    logic [1:0]  size_sel;
    logic [31:0] store_addr, store_data;

    logic [31:0] a1, wd1, rdata1, a3, wd3, rdata3;
    logic        rd1, wr1, busy1, done1, err1;
    logic        rd3, wr3, busy3, done3, err3;

    store_size_rmw #(.MEM_READ_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .size_sel(size_sel),
        .store_addr(store_addr), .store_data(store_data), .mem_addr(a1),
        .mem_rd(rd1), .mem_rdata(rdata1), .mem_wr(wr1), .mem_wdata(wd1),
        .busy(busy1), .done(done1), .err(err1)
    );

    store_size_rmw #(.MEM_READ_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .size_sel(size_sel),
        .store_addr(store_addr), .store_data(store_data), .mem_addr(a3),
        .mem_rd(rd3), .mem_rdata(rdata3), .mem_wr(wr3), .mem_wdata(wd3),
        .busy(busy3), .done(done3), .err(err3)
    );

    // Memory models: read data is valid only in the cycle MEM_READ_LATENCY
    // after mem_rd, garbage otherwise, so a mistimed sample is visible.
    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    logic        rp1;
    logic [2:0]  rp3;
    logic        pre_en, pre_sel;
    logic [31:0] pre_addr, pre_data;

    always @(posedge clk) begin
        rp1 <= rd1;
        rp3 <= {rp3[1:0], rd3};
        if (wr1) mem1[a1[11:2]] <= wd1;
        if (wr3) mem3[a3[11:2]] <= wd3;
        if (pre_en && !pre_sel) mem1[pre_addr[11:2]] <= pre_data;
        if (pre_en &&  pre_sel) mem3[pre_addr[11:2]] <= pre_data;
    end

    assign rdata1 = rp1    ? mem1[a1[11:2]] : 32'hBAD0BAD0;
    assign rdata3 = rp3[2] ? mem3[a3[11:2]] : 32'hBAD0BAD0;

    logic        sel;
    logic [31:0] o_addr, o_wd;
    logic        o_rd, o_wr, o_busy, o_done, o_err;
    assign o_addr = sel ? a3    : a1;
    assign o_wd   = sel ? wd3   : wd1;
    assign o_rd   = sel ? rd3   : rd1;
    assign o_wr   = sel ? wr3   : wr1;
    assign o_busy = sel ? busy3 : busy1;
    assign o_done = sel ? done3 : done1;
    assign o_err  = sel ? err3  : err1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memword;
        logic        err;
        logic        rd;
        int          lat;
    } exp_t;
    exp_t sb[$];

    task automatic set_start(input logic v);
        if (sel) start3 = v;
        else     start1 = v;
    endtask

    task automatic run_op(input string tag, input logic s, input logic [1:0] sz,
                          input logic [31:0] ad, input logic [31:0] dt,
                          input logic [31:0] old, input logic [31:0] ew,
                          input logic ee, input int lat, input logic inject);
        exp_t e;
        int wr_cnt, rd_cnt, both, addr_bad, done_cnt, done_cyc, wr_cyc;
        logic [31:0] got_wd, memnow;
        logic got_err, busy_at_done;
        wr_cnt = 0; rd_cnt = 0; both = 0; addr_bad = 0; done_cnt = 0;
        done_cyc = -1; wr_cyc = -1; got_wd = '0; got_err = 1'b0; busy_at_done = 1'b0;

        @(negedge clk);
        pre_sel = s; pre_addr = ad; pre_data = old; pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;

        e.addr = {ad[31:2], 2'b00};
        e.wdata = ew;
        e.memword = ee ? old : ew;
        e.err = ee;
        e.rd = !ee && (sz != 2'b00);
        e.lat = lat;
        sb.push_back(e);

        sel = s;
        size_sel = sz; store_addr = ad; store_data = dt;
        set_start(1'b1);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) set_start(1'b0);
            if (inject && c == 2) begin
                size_sel = 2'b00; store_addr = ad + 32'd4; store_data = 32'h12345678;
                set_start(1'b1);
            end
            if (inject && c == 3) set_start(1'b0);
            if (o_rd) rd_cnt++;
            if (o_wr) begin
                wr_cnt++;
                wr_cyc = c;
                got_wd = o_wd;
            end
            if (o_rd && o_wr) both++;
            if (o_busy && o_addr !== e.addr) addr_bad++;
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    got_err = o_err;
                    busy_at_done = o_busy;
                end
            end
            if (done_cyc >= 0 && c >= done_cyc + 4) break;
        end

        e = sb.pop_front();
        memnow = s ? mem3[ad[11:2]] : mem1[ad[11:2]];
        chk({tag, " done_cycle"}, done_cyc, e.lat);
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " err"}, {31'b0, got_err}, {31'b0, e.err});
        chk({tag, " busy_at_done"}, {31'b0, busy_at_done}, 32'd0);
        chk({tag, " writes"}, wr_cnt, e.err ? 0 : 1);
        chk({tag, " reads"}, rd_cnt, e.rd ? 1 : 0);
        chk({tag, " rd_wr_overlap"}, both, 0);
        chk({tag, " addr_stable"}, addr_bad, 0);
        if (!e.err) begin
            chk({tag, " wdata"}, got_wd, e.wdata);
            chk({tag, " write_cycle"}, wr_cyc, e.lat - 1);
        end
        chk({tag, " mem_after"}, memnow, e.memword);
    endtask

    initial begin
        int guard;
        reset_n = 1'b0;
        start1 = 1'b0; start3 = 1'b0; size_sel = 2'b00;
        store_addr = '0; store_data = '0;
        pre_en = 1'b0; pre_sel = 1'b0; pre_addr = '0; pre_data = '0;
        sel = 1'b0;
        #1;
        chk("reset mem_addr", a1, 32'd0);
        chk("reset mem_wdata", wd1, 32'd0);
        chk("reset strobes", {27'b0, rd1, wr1, busy1, done1, err1}, 32'd0);
        chk("reset strobes lat3", {27'b0, rd3, wr3, busy3, done3, err3}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle strobes", {27'b0, rd1, wr1, busy1, done1, err1}, 32'd0);

        run_op("SW 0x100", 1'b0, 2'b00, 32'h100, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0);
        run_op("SB 0x203", 1'b0, 2'b10, 32'h203, 32'h000000AB, 32'h11223344, 32'hAB223344, 1'b0, 4, 1'b0);
        run_op("SB 0x202", 1'b0, 2'b10, 32'h202, 32'h000000AB, 32'h11223344, 32'h11AB3344, 1'b0, 4, 1'b0);
        run_op("SB 0x201", 1'b0, 2'b10, 32'h201, 32'h000000AB, 32'h11223344, 32'h1122AB44, 1'b0, 4, 1'b0);
        run_op("SB 0x200", 1'b0, 2'b10, 32'h200, 32'h000000AB, 32'h11223344, 32'h112233AB, 1'b0, 4, 1'b0);
        run_op("SH 0x302", 1'b0, 2'b01, 32'h302, 32'h00001234, 32'hCAFEF00D, 32'h1234F00D, 1'b0, 4, 1'b0);
        run_op("SH 0x300", 1'b0, 2'b01, 32'h300, 32'h00001234, 32'hCAFEF00D, 32'hCAFE1234, 1'b0, 4, 1'b0);
        run_op("SH 0x301", 1'b0, 2'b01, 32'h301, 32'h00001234, 32'h55AA55AA, 32'h0, 1'b1, 1, 1'b0);
        run_op("ILL 0x400", 1'b0, 2'b11, 32'h400, 32'h00001234, 32'h66778899, 32'h0, 1'b1, 1, 1'b0);
        run_op("SW 0x102", 1'b0, 2'b00, 32'h102, 32'hFEEDFACE, 32'h01020304, 32'h0, 1'b1, 1, 1'b0);
        run_op("SB lat3 0x500", 1'b1, 2'b10, 32'h500, 32'h000000FF, 32'h00000000, 32'h000000FF, 1'b0, 6, 1'b1);

        // Reset in the middle of a byte store's write cycle.
        sel = 1'b0;
        @(negedge clk);
        pre_sel = 1'b0; pre_addr = 32'h600; pre_data = 32'h55667788; pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
        size_sel = 2'b10; store_addr = 32'h601; store_data = 32'h000000CC;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        guard = 0;
        while (!wr1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_mid reached write", {31'b0, wr1}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid mem_wr", {31'b0, wr1}, 32'd0);
        chk("rst_mid busy", {31'b0, busy1}, 32'd0);
        chk("rst_mid done", {31'b0, done1}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        guard = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done1 || wr1) guard++;
        end
        chk("rst_mid no done/write after", guard, 0);
        chk("rst_mid mem unchanged", mem1[10'h180], 32'h55667788);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
